tone_event_queue: RTL
=====================

// Module: tone_event_queue
// PURPOSE
//  Upstream feeder for the square-wave tone generator. Buffers vend/error feedback
//  requests from the vending controller and replays them one at a time, so a tone is never
//  cut short by a later request. Drives the generator's vend_event / error_event /
//  item_select inputs and leaves a silent gap between tones.
// PARAMETERS
//  CLOCK_HZ  100_000_000  system clock frequency
//  TONE_MS   150          tone length; must equal the generator's TONE_MS
//  GAP_MS    50           silence inserted after each tone
//  DEPTH     4            queue entries; power of two, >= 2
// PORTS
//  clk            in   1  system clock; the only clock
//  rst_n          in   1  asynchronous, active-low reset
//  vend_req       in   1  one-cycle request: vend tone for req_item
//  error_req      in   1  one-cycle request: error tone
//  req_item       in   2  item index, sampled with vend_req
//  clear_overflow in   1  clears the overflow flag
//  vend_event     out  1  one-cycle pulse to the tone generator
//  error_event    out  1  one-cycle pulse to the tone generator
//  item_select    out  2  item for the current tone; held stable through PLAY and GAP
//  busy           out  1  high when FSM != IDLE or the queue is non-empty
//  queue_count    out  $clog2(DEPTH)+1  number of occupied entries
//  overflow       out  1  sticky: a request was dropped
//  drop_count     out  8  saturating count of dropped requests
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset values: all outputs 0; FIFO pointers 0; FSM in IDLE; timer 0.
//  Reset mid-tone discards the queue, drops both event pulses, and clears the flags.
//  Entry format: {is_err, item[1:0]}. An error entry stores item = 0.
//  Push arbitration:
//   - error_req wins over vend_req in the same cycle; the vend request is dropped.
//   - A dropped request sets overflow and increments drop_count.
//  Full queue:
//   - A push into a full queue is dropped (overflow=1, drop_count+1), unless a pop
//     happens in the same cycle; then the push is accepted and the count is unchanged.
//   - Push into an empty queue while the FSM is idle: a normal write; no bypass.
//  Overflow flag: clear_overflow clears overflow only. It loses to a simultaneous drop,
//   which keeps overflow at 1. drop_count is cleared only by reset; it saturates at 255.
//  FSM states: IDLE, FIRE, PLAY, GAP.
//   IDLE: if the queue is non-empty, pop the head. Latch item_select and is_err. Go to FIRE.
//   FIRE: one cycle. error_event = is_err and vend_event = !is_err, both registered.
//         Load timer = TONE_CYCLES-1. Go to PLAY.
//   PLAY: decrement the timer. At 0, load timer = GAP_CYCLES-1 and go to GAP.
//   GAP:  decrement the timer. At 0, go to IDLE. If the queue is non-empty, the next
//         IDLE cycle pops, so back-to-back tones are spaced by exactly
//         1+TONE_CYCLES+GAP_CYCLES+1 cycles between pulses.
//  Latency: a request sampled at edge k gives its event pulse in the cycle after edge k+2
//   when the queue was empty and the FSM was idle.
//  Constants: TONE_CYCLES = (CLOCK_HZ/1000)*TONE_MS and GAP_CYCLES = (CLOCK_HZ/1000)*GAP_MS,
//   both 32-bit. GAP_MS = 0 is legal: GAP lasts 1 cycle.
//  Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy comes from queue_count,
//   not from pointer compare.
// STRUCTURE
//  Shared package: entry field widths, state encoding, and the ms-to-cycles helper.
//   The tone generator uses the same helper.
//  One sub-module: event_fifo, a synchronous FIFO with push/pop/full/empty/count and
//   the DEPTH parameter. The FSM, timer and drop logic live in the top level.
// TESTING  (sim: CLOCK_HZ=10_000, TONE_MS=1, GAP_MS=1 -> 10-cycle tone, 10-cycle gap)
//  1. Single vend_req, req_item=2 at edge 5 -> vend_event high for one cycle after edge 7;
//     item_select=2 until IDLE; busy low 22 cycles later.
//  2. vend_req and error_req in the same cycle -> error_event only; overflow=1, drop_count=1.
//  3. Six vend_reqs (items 0,1,2,3,0,1) on consecutive cycles with DEPTH=4 ->
//     items 0,1,2,3,0 play in order, 22 cycles apart; one drop recorded.
//  4. Push and pop in the same cycle at full -> push accepted, queue_count stays 4,
//     overflow stays 0.
//  5. rst_n low mid-PLAY with 2 entries queued -> all outputs 0 immediately;
//     no pulses after release.
//  6. clear_overflow together with a drop -> overflow remains 1; alone -> overflow 0,
//     drop_count unchanged.

Source files
------------

// File: rtl/tone_event_queue_pkg.sv
// Shared definitions for the tone event queue and the tone generator.
//   entry_t       queued request: {is_err, item}
//   state_t       replay FSM encoding
//   ms_to_cycles  milliseconds to clock cycles (also used by the tone generator)
package tone_event_queue_pkg;

   localparam int unsigned ITEM_W = 2;

   typedef struct packed {
      logic              is_err;
      logic [ITEM_W-1:0] item;
   } entry_t;

   localparam int unsigned ENTRY_W = $bits(entry_t);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_PLAY = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   function automatic logic [31:0] ms_to_cycles(input int unsigned clock_hz,
                                                input int unsigned ms);
      return 32'((clock_hz / 1000) * ms);
   endfunction

   // Down-counter load value for an interval of n cycles; a zero-length
   // interval still occupies one cycle rather than wrapping the counter.
   function automatic logic [31:0] timer_load(input logic [31:0] n);
      return (n == 32'd0) ? 32'd0 : n - 32'd1;
   endfunction

endpackage

// File: rtl/tone_event_queue_event_fifo.sv
// Synchronous FIFO holding pending tone requests.
//   clk, rst_n  clock and asynchronous active-low reset
//   push, wdata write request and data; accepted when not full or popping
//   pop         read request; ignored when empty
//   rdata       head entry (valid when !empty)
//   full, empty occupancy flags, derived from count
//   count       number of occupied entries
module tone_event_queue_event_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full queue still accepts.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/tone_event_queue.sv
// Tone event queue: buffers vend/error feedback requests and replays them to
// the square-wave tone generator one at a time with a silent gap after each.
//   clk, rst_n      clock and asynchronous active-low reset
//   vend_req        one-cycle request for a vend tone of req_item
//   error_req       one-cycle request for an error tone (wins over vend_req)
//   req_item        item index sampled with vend_req
//   clear_overflow  clears the sticky overflow flag
//   vend_event      one-cycle pulse to the generator
//   error_event     one-cycle pulse to the generator
//   item_select     item of the current tone, held through PLAY and GAP
//   busy            FSM not idle or queue non-empty
//   queue_count     occupied queue entries
//   overflow        sticky: a request was dropped
//   drop_count      saturating count of dropped requests
//
// state | meaning
// IDLE  | waiting; pops the queue head when one is available
// FIRE  | one cycle; emits the event pulse and loads the tone timer
// PLAY  | tone sounding; timer counts down to 0
// GAP   | silence after the tone; timer counts down to 0
module tone_event_queue
   import tone_event_queue_pkg::*;
#(
   parameter int unsigned CLOCK_HZ = 100_000_000,
   parameter int unsigned TONE_MS  = 150,
   parameter int unsigned GAP_MS   = 50,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   vend_req,
   input  logic                   error_req,
   input  logic [ITEM_W-1:0]      req_item,
   input  logic                   clear_overflow,
   output logic                   vend_event,
   output logic                   error_event,
   output logic [ITEM_W-1:0]      item_select,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic                   overflow,
   output logic [7:0]             drop_count
);

   localparam logic [31:0] TONE_CYCLES = ms_to_cycles(CLOCK_HZ, TONE_MS);
   localparam logic [31:0] GAP_CYCLES  = ms_to_cycles(CLOCK_HZ, GAP_MS);
   localparam logic [31:0] TONE_LOAD   = timer_load(TONE_CYCLES);
   localparam logic [31:0] GAP_LOAD    = timer_load(GAP_CYCLES);

   state_t               state;
   logic [31:0]          timer;
   logic                 is_err_q;
   entry_t               push_entry;
   entry_t               head;
   logic [ENTRY_W-1:0]   head_raw;
   logic                 push_req;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 drop_arb;
   logic                 drop_full;
   logic [1:0]           drop_inc;
   logic [8:0]           drop_sum;

   assign push_req = vend_req || error_req;

   always_comb begin
      push_entry = '0;
      if (error_req) begin
         push_entry.is_err = 1'b1;
         push_entry.item   = '0;
      end else begin
         push_entry.is_err = 1'b0;
         push_entry.item   = req_item;
      end
   end

   assign pop       = (state == ST_IDLE) && !fifo_empty;
   assign drop_arb  = vend_req && error_req;
   assign drop_full = push_req && fifo_full && !pop;
   // Both can happen together: the losing vend and the rejected error each count.
   assign drop_inc  = {1'b0, drop_arb} + {1'b0, drop_full};
   assign drop_sum  = {1'b0, drop_count} + {7'd0, drop_inc};
   assign head      = entry_t'(head_raw);
   assign busy      = (state != ST_IDLE) || !fifo_empty;

   tone_event_queue_event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_event_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head_raw),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (queue_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         timer       <= '0;
         is_err_q    <= 1'b0;
         item_select <= '0;
         vend_event  <= 1'b0;
         error_event <= 1'b0;
      end else begin
         vend_event  <= 1'b0;
         error_event <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  item_select <= head.item;
                  is_err_q    <= head.is_err;
                  state       <= ST_FIRE;
               end
            end
            ST_FIRE: begin
               vend_event  <= !is_err_q;
               error_event <= is_err_q;
               timer       <= TONE_LOAD;
               state       <= ST_PLAY;
            end
            ST_PLAY: begin
               if (timer == '0) begin
                  timer <= GAP_LOAD;
                  state <= ST_GAP;
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            ST_GAP: begin
               if (timer == '0) state <= ST_IDLE;
               else             timer <= timer - 32'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         // A drop in the same cycle overrides clear_overflow.
         if (drop_inc != 2'd0)    overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
         if (drop_inc != 2'd0)
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

endmodule
